regs_wb_arbiter: RTL

- Shares the single register-file write port (`we`/`waddr`/`wdata`) between two writers:
  - the in-order execute stage (port 0);
  - the multi-cycle unit (mul/div/load, port 1).
- Keeps a scoreboard of registers with in-flight port-1 results and flags read hazards to id.
- Sits between ex/multi-cycle unit and regs; drives regs' write port through one register stage.

---
 rtl/regs_wb_arbiter_pkg.sv | 15 +
 rtl/regs_scoreboard.sv | 48 ++++
 rtl/regs_wb_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/regs_wb_arbiter_pkg.sv
// Shared widths, constants and FSM encoding for the register-file write-back arbiter.
package regs_wb_arbiter_pkg;

    localparam int REGS_ADDR_W = 5;
    localparam int REGS_DATA_W = 32;

    localparam logic [REGS_ADDR_W-1:0] ZERO_REG     = '0;
    localparam logic                   WRITE_ENABLE = 1'b1;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regs_scoreboard.sv
// Pending-write scoreboard for multi-cycle results: set on issue, clear on port-1 grant,
// combinational read-hazard and WAW lookups.
module regs_scoreboard
    import regs_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = REGS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue,
    input  logic [ADDR_W-1:0] i_issue_rd,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic              o_issue_stall,
    output logic              o_hazard1,
    output logic              o_hazard2
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;
    logic            w_clr_hit;
    logic            w_set;

    // A grant retiring the same register this cycle frees the slot for the new issue.
    assign w_clr_hit     = i_clr_en && (i_clr_addr == i_issue_rd);
    assign o_issue_stall = !rst && i_issue && r_pending[i_issue_rd] && !w_clr_hit;
    assign w_set         = i_issue && !o_issue_stall && (i_issue_rd != ADDR_W'(ZERO_REG));

    assign o_hazard1 = !rst && r_pending[i_raddr1];
    assign o_hazard2 = !rst && r_pending[i_raddr2];

    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en) w_pending_nxt[i_clr_addr] = 1'b0;
        if (w_set)    w_pending_nxt[i_issue_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_pending <= '0;
        else     r_pending <= w_pending_nxt;
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Two-writer arbiter for the register-file write port with anti-starvation FSM and a registered
// write stage. Define REGS_WB_ARBITER_PERF_EN to add conflict/FORCE-entry counters.
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = REGS_ADDR_W,
    parameter int DATA_W     = REGS_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              ex_stall_o,
    input  logic              mc_valid_i,
    output logic              mc_ready_o,
    input  logic [ADDR_W-1:0] mc_waddr_i,
    input  logic [DATA_W-1:0] mc_wdata_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    output logic              issue_stall_o,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              hazard1_o,
    output logic              hazard2_o,
`ifdef REGS_WB_ARBITER_PERF_EN
    output logic [31:0]       conflict_cnt_o,
    output logic [31:0]       force_cnt_o,
`endif
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o
);

    arb_state_e r_state, w_state_nxt;
    logic [3:0] r_starve_cnt, w_starve_cnt_nxt;
    logic       w_grant0, w_grant1;

    always_comb begin
        w_state_nxt      = r_state;
        w_starve_cnt_nxt = r_starve_cnt;
        w_grant0         = 1'b0;
        w_grant1         = 1'b0;
        if (!rst) begin
            case (r_state)
                NORMAL: begin
                    if (ex_we_i) begin
                        w_grant0 = 1'b1;
                        if (mc_valid_i) begin
                            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
                            if (r_starve_cnt == 4'(STARVE_MAX - 1)) w_state_nxt = FORCE;
                        end else begin
                            w_starve_cnt_nxt = '0;
                        end
                    end else if (mc_valid_i) begin
                        w_grant1         = 1'b1;
                        w_starve_cnt_nxt = '0;
                    end
                end
                FORCE: begin
                    // If the starved result vanished, port 0 simply proceeds this cycle.
                    w_state_nxt      = NORMAL;
                    w_starve_cnt_nxt = '0;
                    if (mc_valid_i)   w_grant1 = 1'b1;
                    else if (ex_we_i) w_grant0 = 1'b1;
                end
                default: w_state_nxt = NORMAL;
            endcase
        end
    end

    assign ex_stall_o = ex_we_i && w_grant1;
    assign mc_ready_o = w_grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= NORMAL;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
        end else begin
            we_o <= 1'b0;
            if (w_grant0) begin
                we_o    <= (ex_waddr_i != ADDR_W'(ZERO_REG)) ? WRITE_ENABLE : 1'b0;
                waddr_o <= ex_waddr_i;
                wdata_o <= ex_wdata_i;
            end else if (w_grant1) begin
                we_o    <= (mc_waddr_i != ADDR_W'(ZERO_REG)) ? WRITE_ENABLE : 1'b0;
                waddr_o <= mc_waddr_i;
                wdata_o <= mc_wdata_i;
            end
        end
    end

    regs_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_issue      (issue_i),
        .i_issue_rd   (issue_rd_i),
        .i_clr_en     (w_grant1),
        .i_clr_addr   (mc_waddr_i),
        .i_raddr1     (raddr1_i),
        .i_raddr2     (raddr2_i),
        .o_issue_stall(issue_stall_o),
        .o_hazard1    (hazard1_o),
        .o_hazard2    (hazard2_o)
    );

`ifdef REGS_WB_ARBITER_PERF_EN
    logic [31:0] r_conflict_cnt, r_force_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_force_cnt    <= '0;
        end else begin
            if (ex_we_i && mc_valid_i)                    r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if (r_state == NORMAL && w_state_nxt == FORCE) r_force_cnt    <= r_force_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
    assign force_cnt_o    = r_force_cnt;
`endif

endmodule
